kernel_seq_ctrl: RTL

KERNEL_SEQ_CTRL -- requirements
Module: kernel_seq_ctrl

---
 rtl/kernel_pkg.sv | 50 +++++
 rtl/kernel_seq_ctrl_if.sv | 43 ++++
 rtl/kernel_mac.sv | 33 +++
 rtl/kernel_seq_ctrl.sv | 98 +++++++++
 4 files changed

// File: rtl/kernel_pkg.sv
// Shared definitions for the kernel sequencer: select codes, FSM states and tap counts.
// KSEQ_CENTER_TAP_EN extends the window with a ninth (centre) tap.
package kernel_pkg;

    localparam logic [3:0] SEL_NONE = 4'd0;
    localparam logic [3:0] SEL_TL   = 4'd1;
    localparam logic [3:0] SEL_TR   = 4'd2;
    localparam logic [3:0] SEL_BL   = 4'd3;
    localparam logic [3:0] SEL_BR   = 4'd4;
    localparam logic [3:0] SEL_R    = 4'd5;
    localparam logic [3:0] SEL_L    = 4'd6;
    localparam logic [3:0] SEL_T    = 4'd7;
    localparam logic [3:0] SEL_B    = 4'd8;
    localparam logic [3:0] SEL_C    = 4'd9;

    localparam int TAPS_EDGE   = 8;
    localparam int TAPS_CENTER = 9;

`ifdef KSEQ_CENTER_TAP_EN
    localparam int TAP_COUNT = TAPS_CENTER;
`else
    localparam int TAP_COUNT = TAPS_EDGE;
`endif

    localparam logic [3:0] LAST_SEL = (TAP_COUNT == TAPS_CENTER) ? SEL_C : SEL_B;

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        DONE
    } state_t;

    // Walk order of the neighbour taps; anything off the list falls back to SEL_NONE.
    function automatic logic [3:0] next_tap(input logic [3:0] sel);
        logic [3:0] nxt;
        case (sel)
            SEL_TL:  nxt = SEL_TR;
            SEL_TR:  nxt = SEL_BL;
            SEL_BL:  nxt = SEL_BR;
            SEL_BR:  nxt = SEL_R;
            SEL_R:   nxt = SEL_L;
            SEL_L:   nxt = SEL_T;
            SEL_T:   nxt = SEL_B;
            SEL_B:   nxt = SEL_C;
            default: nxt = SEL_NONE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/kernel_seq_ctrl_if.sv
// Handshake bundle between the kernel sequencer, its weight mux and the pixel source.
// KSEQ_CENTER_TAP_EN adds the centre weight c_w.
interface kernel_seq_ctrl_if #(
    parameter int PIX_W = 8,
    parameter int W_W   = 4,
    parameter int ACC_W = 16
);

    logic             start;
    logic             busy;
    logic [3:0]       select;
    logic [W_W-1:0]   k_w;
    logic             pix_req;
    logic             pix_valid;
    logic [PIX_W-1:0] pix_in;
    logic [ACC_W-1:0] result;
    logic             result_valid;

`ifdef KSEQ_CENTER_TAP_EN
    logic [W_W-1:0]   c_w;

    modport master (
        output start, k_w, pix_valid, pix_in, c_w,
        input  busy, select, pix_req, result, result_valid
    );

    modport slave (
        input  start, k_w, pix_valid, pix_in, c_w,
        output busy, select, pix_req, result, result_valid
    );
`else
    modport master (
        output start, k_w, pix_valid, pix_in,
        input  busy, select, pix_req, result, result_valid
    );

    modport slave (
        input  start, k_w, pix_valid, pix_in,
        output busy, select, pix_req, result, result_valid
    );
`endif

endinterface

// File: rtl/kernel_mac.sv
// Unsigned multiply-accumulate: acc clears on 'clear' and adds a*b on 'enable'.
module kernel_mac #(
    parameter int A_W   = 8,
    parameter int B_W   = 4,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    output logic [ACC_W-1:0] acc
);

    logic [A_W+B_W-1:0] prod;

    always_comb begin
        prod = {{B_W{1'b0}}, a} * {{A_W{1'b0}}, b};
    end

    // The full product is zero-extended; ACC_W leaves headroom for every tap summed.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/kernel_seq_ctrl.sv
// Steps the weight mux through the neighbour taps, accumulating k_w*pixel per handshake beat.
// KSEQ_CENTER_TAP_EN appends a centre tap weighted by c_w.
module kernel_seq_ctrl
    import kernel_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int W_W   = 4,
    parameter int ACC_W = 16
) (
    input logic              clk,
    input logic              rst,
    kernel_seq_ctrl_if.slave bus
);

    state_t           state;
    state_t           state_next;
    logic [3:0]       tap_idx;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] result_q;
    logic [W_W-1:0]   weight;
    logic             accept;
    logic             beat;

    always_comb begin
        accept = (state == IDLE) && bus.start;
        beat   = (state == STEP) && bus.pix_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = STEP;
            STEP:    if (bus.pix_valid && (tap_idx == LAST_SEL)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result is visible during DONE straight from the accumulator, then held in result_q.
    always_comb begin
        bus.busy         = (state != IDLE);
        bus.pix_req      = (state == STEP);
        bus.select       = (state == STEP) ? tap_idx : SEL_NONE;
        bus.result_valid = (state == DONE);
        bus.result       = (state == DONE) ? acc : result_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_idx  <= SEL_NONE;
            result_q <= '0;
        end else begin
            if (accept) begin
                tap_idx <= SEL_TL;
            end else if (beat) begin
                tap_idx <= next_tap(tap_idx);
            end else if (state == DONE) begin
                tap_idx <= SEL_NONE;
            end
            if (state == DONE) begin
                result_q <= acc;
            end
        end
    end

`ifdef KSEQ_CENTER_TAP_EN
    always_comb begin
        weight = (tap_idx == SEL_C) ? bus.c_w : bus.k_w;
    end
`else
    always_comb begin
        weight = bus.k_w;
    end
`endif

    kernel_mac #(
        .A_W   (PIX_W),
        .B_W   (W_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable (beat),
        .a      (bus.pix_in),
        .b      (weight),
        .acc    (acc)
    );

endmodule
